// File: rtl/ctrl_seq_if.sv
// ctrl_seq_if: control/status bundle between the sequencing control unit and
// the surrounding datapath (instruction ROM, ALU, fetch unit, register file,
// data memory).
//   Start, Instruction, AluZero        : datapath -> control
//   PcInit, PcEn, Jump, BranchEn,
//   RegWrEn, MemRdEn, MemWrEn, Stall,
//   Done, CycleCount                   : control -> datapath
// master: datapath/environment side; slave: ctrl_seq side.
interface ctrl_seq_if #(
  parameter int unsigned INSTR_W = 9,
  parameter int unsigned CNT_W   = 16
);
  logic               Start;
  logic [INSTR_W-1:0] Instruction;
  logic               AluZero;
  logic               PcInit;
  logic               PcEn;
  logic               Jump;
  logic               BranchEn;
  logic               RegWrEn;
  logic               MemRdEn;
  logic               MemWrEn;
  logic               Stall;
  logic               Done;
  logic [CNT_W-1:0]   CycleCount;

  modport master (
    output Start, Instruction, AluZero,
    input  PcInit, PcEn, Jump, BranchEn, RegWrEn, MemRdEn, MemWrEn, Stall, Done, CycleCount
  );

  modport slave (
    input  Start, Instruction, AluZero,
    output PcInit, PcEn, Jump, BranchEn, RegWrEn, MemRdEn, MemWrEn, Stall, Done, CycleCount
  );
endinterface

// File: rtl/ctrl_seq.sv
// ctrl_seq: sequencing control unit for the single-cycle processor.
// Decodes the opcode field into jump/branch/register-write/memory controls,
// runs an IDLE/RUN/WAIT_MEM/HALTED state machine, keeps a registered zero
// flag for conditional branches, stalls the PC during multi-cycle loads and
// counts active cycles with a saturating counter.
// Ports:
//   Clk   : clock, all state updates on the rising edge
//   Reset : synchronous, active-high reset
//   bus   : ctrl_seq_if slave modport (inputs Start/Instruction/AluZero,
//           control outputs and CycleCount)
module ctrl_seq #(
  parameter int unsigned     INSTR_W  = 9,
  parameter int unsigned     OPC_LSB  = 0,
  parameter int unsigned     OPC_W    = 3,
  parameter logic [OPC_W-1:0] OP_JMP  = 3'd1,
  parameter logic [OPC_W-1:0] OP_BR   = 3'd2,
  parameter logic [OPC_W-1:0] OP_LD   = 3'd3,
  parameter logic [OPC_W-1:0] OP_ST   = 3'd4,
  parameter logic [OPC_W-1:0] OP_HALT = 3'd7,
  parameter int unsigned     LOAD_LAT = 2,
  parameter int unsigned     CNT_W    = 16
) (
  input logic     Clk,
  input logic     Reset,
  ctrl_seq_if.slave bus
);

  // Wide enough to hold LOAD_LAT-1; at least one bit.
  localparam int unsigned WaitW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StWaitMem, StHalted} state_e;

  state_e           state_q, state_d;
  logic             zero_q, zero_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OPC_W-1:0] opc;

  logic pc_init, pc_en, jump, branch_en, reg_wr_en, mem_rd_en, mem_wr_en, stall, done;

  assign opc = bus.Instruction[OPC_LSB +: OPC_W];

  // Fields outside the opcode are decoded elsewhere in the datapath.
  logic unused_instr;
  assign unused_instr = ^bus.Instruction;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      zero_q  <= 1'b0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      zero_q  <= zero_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    zero_d    = zero_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    pc_init   = 1'b0;
    pc_en     = 1'b0;
    jump      = 1'b0;
    branch_en = 1'b0;
    reg_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;

    // Saturating count of active cycles.
    if ((state_q == StRun || state_q == StWaitMem) && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (bus.Start) begin
          pc_init = 1'b1;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (opc == OP_JMP) begin
          jump  = 1'b1;
          pc_en = 1'b1;
        end else if (opc == OP_BR) begin
          // Flag captured by an earlier ALU op, not this cycle's AluZero.
          branch_en = zero_q;
          pc_en     = 1'b1;
        end else if (opc == OP_LD) begin
          mem_rd_en = 1'b1;
          stall     = 1'b1;
          wait_d    = WaitW'(LOAD_LAT - 1);
          state_d   = StWaitMem;
        end else if (opc == OP_ST) begin
          mem_wr_en = 1'b1;
          pc_en     = 1'b1;
        end else if (opc == OP_HALT) begin
          state_d = StHalted;
        end else begin
          reg_wr_en = 1'b1;
          pc_en     = 1'b1;
          zero_d    = bus.AluZero;
        end
      end
      StWaitMem: begin
        mem_rd_en = 1'b1;
        if (wait_q != '0) begin
          stall  = 1'b1;
          wait_d = wait_q - WaitW'(1);
        end else begin
          reg_wr_en = 1'b1;
          pc_en     = 1'b1;
          state_d   = StRun;
        end
      end
      StHalted: begin
        done = 1'b1;
        if (bus.Start) begin
          pc_init = 1'b1;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.PcInit     = pc_init;
  assign bus.PcEn       = pc_en;
  assign bus.Jump       = jump;
  assign bus.BranchEn   = branch_en;
  assign bus.RegWrEn    = reg_wr_en;
  assign bus.MemRdEn    = mem_rd_en;
  assign bus.MemWrEn    = mem_wr_en;
  assign bus.Stall      = stall;
  assign bus.Done       = done;
  assign bus.CycleCount = cnt_q;

endmodule
